// File: rtl/exp_sigma_table_pkg.sv
// Shared constants, types and index helpers for the exp(x*sigma) table.
// Holds the index grid limits, widths, FSM encoding and x-to-offset mapping.
package exp_sigma_table_pkg;

    localparam int x_min     = -307;
    localparam int x_max     = 280;
    localparam int pathWidth = 10;
    localparam int dataWidth = 18;
    localparam int DEPTH     = x_max - x_min + 1;
    localparam int ramAw     = 10;

    typedef logic signed [pathWidth-1:0] path_t;
    typedef logic signed [pathWidth:0]   off_t;
    typedef logic        [dataWidth-1:0] data_t;
    typedef logic        [ramAw-1:0]     addr_t;
    typedef logic        [ramAw-1:0]     cnt_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        REQ   = 2'd1,
        LOAD  = 2'd2,
        READY = 2'd3
    } state_t;

    localparam path_t X_MIN_P = path_t'(x_min);
    localparam path_t X_MAX_P = path_t'(x_max);
    localparam cnt_t  DEPTH_C = cnt_t'(DEPTH);

    // One extra bit so x_max - x_min (587) cannot overflow.
    function automatic off_t x_to_off(input path_t x);
        return off_t'(x) - off_t'(x_min);
    endfunction

    // Callers only pass in-range indices, so the offset fits the RAM address.
    function automatic addr_t x_to_addr(input path_t x);
        return addr_t'(x_to_off(x));
    endfunction

endpackage

// File: rtl/ram_sdp_18x1024.sv
// Simple dual-port RAM: one write port, one registered read port.
// Ports: clk, we/waddr/wdata (write), re/raddr (read request), rdata (registered).
module ram_sdp_18x1024
    import exp_sigma_table_pkg::*;
(
    input  logic  clk,
    input  logic  we,
    input  addr_t waddr,
    input  data_t wdata,
    input  logic  re,
    input  addr_t raddr,
    output data_t rdata
);

    data_t mem [1024];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/exp_sigma_table.sv
// Captures the generator's exp(x*sigma) stream into RAM, then serves lookups.
// Ports: CLK/iRSTn; iLoad/oStart handshake; iData/iAddr/iValid/iDone stream;
//        iRdReq/iRdAddr lookups -> oRdData/oRdValid/oRdClamp; oReady, oError.
module exp_sigma_table
    import exp_sigma_table_pkg::*;
(
    input  logic  CLK,
    input  logic  iRSTn,
    input  logic  iLoad,
    output logic  oStart,
    input  data_t iData,
    input  path_t iAddr,
    input  logic  iValid,
    input  logic  iDone,
    input  logic  iRdReq,
    input  path_t iRdAddr,
    output data_t oRdData,
    output logic  oRdValid,
    output logic  oRdClamp,
    output logic  oReady,
    output logic  oError
);

    state_t state, state_n;
    cnt_t   cnt, cnt_n;
    logic   err, err_n;
    logic   done_q;
    logic   done_edge;
    logic   in_rng;
    logic   we;

    assign done_edge = iDone & ~done_q;
    assign in_rng    = (iAddr >= X_MIN_P) && (iAddr <= X_MAX_P);

    always_ff @(posedge CLK or negedge iRSTn) begin
        if (!iRSTn) begin
            state  <= IDLE;
            cnt    <= '0;
            err    <= 1'b0;
            done_q <= 1'b0;
        end else begin
            state  <= state_n;
            cnt    <= cnt_n;
            err    <= err_n;
            done_q <= iDone;
        end
    end

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        err_n   = err;
        we      = 1'b0;
        unique case (state)
            IDLE: begin
                if (iLoad) state_n = REQ;
            end
            REQ: begin
                cnt_n   = '0;
                err_n   = 1'b0;
                state_n = LOAD;
            end
            LOAD: begin
                if (iValid) begin
                    if (in_rng) begin
                        we = 1'b1;
                        if (cnt != DEPTH_C) cnt_n = cnt + cnt_t'(1);
                    end else begin
                        err_n = 1'b1;
                    end
                end
                // cnt_n already includes a write landing in the done cycle.
                if (done_edge) begin
                    state_n = READY;
                    if (cnt_n != DEPTH_C) err_n = 1'b1;
                end
            end
            READY: begin
                if (iLoad) state_n = REQ;
            end
        endcase
    end

    assign oStart = (state == REQ);
    assign oReady = (state == READY);
    assign oError = err;

    logic  rd_acc;
    logic  lo, hi;
    path_t rd_x;
    data_t ram_q;
    logic  v1, c1;

    assign rd_acc = iRdReq & oReady;
    assign lo     = iRdAddr < X_MIN_P;
    assign hi     = iRdAddr > X_MAX_P;
    assign rd_x   = lo ? X_MIN_P : (hi ? X_MAX_P : iRdAddr);

    ram_sdp_18x1024 u_ram (
        .clk   (CLK),
        .we    (we),
        .waddr (x_to_addr(iAddr)),
        .wdata (iData),
        .re    (rd_acc),
        .raddr (x_to_addr(rd_x)),
        .rdata (ram_q)
    );

    always_ff @(posedge CLK or negedge iRSTn) begin
        if (!iRSTn) begin
            v1       <= 1'b0;
            c1       <= 1'b0;
            oRdValid <= 1'b0;
            oRdClamp <= 1'b0;
            oRdData  <= '0;
        end else begin
            v1       <= rd_acc;
            c1       <= rd_acc & (lo | hi);
            oRdValid <= v1;
            oRdClamp <= v1 & c1;
            if (v1) oRdData <= ram_q;
        end
    end

endmodule

// File: tb/tb_exp_sigma_table.sv
// Directed bench for exp_sigma_table: loads, lookups, clamping, errors, reset.
// Drives a model generator stream and checks against hand-computed values.
module tb_exp_sigma_table;

    logic               CLK = 1'b0;
    logic               iRSTn = 1'b0;
    logic               iLoad = 1'b0;
    logic               oStart;
    logic [17:0]        iData = '0;
    logic signed [9:0]  iAddr = '0;
    logic               iValid = 1'b0;
    logic               iDone = 1'b0;
    logic               iRdReq = 1'b0;
    logic signed [9:0]  iRdAddr = '0;
    logic [17:0]        oRdData;
    logic               oRdValid;
    logic               oRdClamp;
    logic               oReady;
    logic               oError;

    int errors = 0;
    int checks = 0;

    exp_sigma_table dut (
        .CLK      (CLK),
        .iRSTn    (iRSTn),
        .iLoad    (iLoad),
        .oStart   (oStart),
        .iData    (iData),
        .iAddr    (iAddr),
        .iValid   (iValid),
        .iDone    (iDone),
        .iRdReq   (iRdReq),
        .iRdAddr  (iRdAddr),
        .oRdData  (oRdData),
        .oRdValid (oRdValid),
        .oRdClamp (oRdClamp),
        .oReady   (oReady),
        .oError   (oError)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic signed [9:0] addr;
        logic [17:0]       data;
        logic              clamp;
    } vec_t;

    vec_t tv [7];

    task automatic check(input string name, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic start_load();
        iLoad = 1'b1;
        step();
        check("start_pulse", 32'(oStart), 1);
        check("ready_drop", 32'(oReady), 0);
        iLoad = 1'b0;
        step();
        check("start_once", 32'(oStart), 0);
    endtask

    task automatic write_stream(input int n, input int dbase, input int bad_at);
        for (int i = 0; i < n; i++) begin
            if (i == bad_at) begin
                iValid = 1'b1;
                iAddr  = 10'sd290;
                iData  = 18'h3ffff;
                step();
                check("bad_idx_err", 32'(oError), 1);
            end
            iValid = 1'b1;
            iAddr  = 10'(i - 307);
            iData  = 18'(i + dbase);
            step();
        end
        iValid = 1'b0;
        iDone  = 1'b1;
        step();
        check("ready_after_done", 32'(oReady), 1);
        iDone = 1'b0;
    endtask

    task automatic read1(input string name, input logic signed [9:0] a,
                         input int expd, input int expc);
        iRdReq  = 1'b1;
        iRdAddr = a;
        step();
        iRdReq = 1'b0;
        step();
        check({name, "_valid"}, 32'(oRdValid), 1);
        check({name, "_data"}, 32'(oRdData), 32'(expd));
        check({name, "_clamp"}, 32'(oRdClamp), 32'(expc));
    endtask

    initial begin
        tv[0] = '{addr: -10'sd307, data: 18'd0,   clamp: 1'b0};
        tv[1] = '{addr: 10'sd0,    data: 18'd307, clamp: 1'b0};
        tv[2] = '{addr: 10'sd280,  data: 18'd587, clamp: 1'b0};
        tv[3] = '{addr: 10'sd300,  data: 18'd587, clamp: 1'b1};
        tv[4] = '{addr: -10'sd400, data: 18'd0,   clamp: 1'b1};
        tv[5] = '{addr: 10'sd100,  data: 18'd407, clamp: 1'b0};
        tv[6] = '{addr: -10'sd1,   data: 18'd306, clamp: 1'b0};

        #3;
        check("rst_start", 32'(oStart), 0);
        check("rst_ready", 32'(oReady), 0);
        check("rst_error", 32'(oError), 0);
        check("rst_valid", 32'(oRdValid), 0);
        check("rst_data", 32'(oRdData), 0);
        check("rst_clamp", 32'(oRdClamp), 0);
        step();
        iRSTn = 1'b1;
        step();
        check("idle_no_start", 32'(oStart), 0);

        // Full load, then table-driven back-to-back lookups.
        start_load();
        write_stream(588, 0, -1);
        check("full_err", 32'(oError), 0);

        for (int i = 0; i <= 7; i++) begin
            if (i < 7) begin
                iRdReq  = 1'b1;
                iRdAddr = tv[i].addr;
            end else begin
                iRdReq = 1'b0;
            end
            step();
            if (i >= 1) begin
                check("vec_valid", 32'(oRdValid), 1);
                check("vec_data", 32'(oRdData), 32'(tv[i-1].data));
                check("vec_clamp", 32'(oRdClamp), 32'(tv[i-1].clamp));
            end
        end
        step();
        check("valid_drop", 32'(oRdValid), 0);

        // Short stream sets error; next full load clears it.
        start_load();
        write_stream(500, 0, -1);
        check("short_err", 32'(oError), 1);
        start_load();
        check("err_clr_req", 32'(oError), 0);
        write_stream(588, 0, -1);
        check("full2_err", 32'(oError), 0);

        // Out-of-range entry mid-stream: flagged, not written.
        start_load();
        write_stream(588, 0, 100);
        check("bad_err_end", 32'(oError), 1);
        read1("bad_rd280", 10'sd280, 587, 0);
        read1("bad_rd300", 10'sd300, 587, 1);

        // Reload from READY with reads in flight.
        iRdReq  = 1'b1;
        iRdAddr = 10'sd0;
        step();
        iLoad   = 1'b1;
        iRdAddr = 10'sd100;
        step();
        check("rl_start", 32'(oStart), 1);
        check("rl_ready", 32'(oReady), 0);
        check("rl_a_valid", 32'(oRdValid), 1);
        check("rl_a_data", 32'(oRdData), 307);
        iLoad   = 1'b0;
        iRdAddr = 10'sd5;
        step();
        check("rl_b_valid", 32'(oRdValid), 1);
        check("rl_b_data", 32'(oRdData), 407);
        iRdReq = 1'b0;
        step();
        check("rl_c_drop", 32'(oRdValid), 0);
        step();
        check("rl_c_drop2", 32'(oRdValid), 0);
        write_stream(588, 1000, -1);
        check("rl_err", 32'(oError), 0);
        read1("rl_new", 10'sd0, 1307, 0);

        // Asynchronous reset in the middle of a load.
        start_load();
        for (int i = 0; i < 200; i++) begin
            iValid = 1'b1;
            iAddr  = 10'(i - 307);
            iData  = 18'(i);
            step();
        end
        iValid = 1'b1;
        iAddr  = 10'(200 - 307);
        iData  = 18'd200;
        check("pre_rst_data", 32'(oRdData), 1307);
        #2 iRSTn = 1'b0;
        #1;
        check("arst_data", 32'(oRdData), 0);
        check("arst_ready", 32'(oReady), 0);
        check("arst_start", 32'(oStart), 0);
        check("arst_error", 32'(oError), 0);
        check("arst_valid", 32'(oRdValid), 0);
        iValid = 1'b0;
        step();
        iRSTn = 1'b1;

        iRdReq  = 1'b1;
        iRdAddr = 10'sd0;
        for (int i = 0; i < 5; i++) begin
            if (i == 3) iRdReq = 1'b0;
            step();
            check("gated_valid", 32'(oRdValid), 0);
        end

        start_load();
        write_stream(588, 0, -1);
        check("post_rst_err", 32'(oError), 0);
        read1("post_rst_280", 10'sd280, 587, 0);
        read1("post_rst_lo", -10'sd307, 0, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
